// File: rtl/gpio_cmd_sequencer.sv
// gpio_cmd_sequencer: turns host commands into held-then-gapped GPIO select words and samples the return word.
module gpio_cmd_sequencer #(
   parameter int HOLD_CYC   = 4,
   parameter int GAP_CYC    = 4,
   parameter int SETTLE_CYC = 2
) (
   input  logic        sys_clk,
   input  logic        _RESET_in,
   input  logic        CMD_valid_in,
   output logic        CMD_ready_out,
   input  logic [2:0]  CMD_op_in,
   input  logic [15:0] CMD_arg_in,
   output logic [31:0] SELECT_out,
   input  logic [31:0] GPIO_in,
   output logic        RESP_valid_out,
   output logic [31:0] RESP_data_out,
   output logic        RESP_last_out,
   output logic        STATUS_full_out,
   output logic [15:0] STATUS_cnt_out,
   output logic        BUSY_out
);
   typedef enum logic [1:0] {IDLE, ASSERT, GAP} state_t;
   localparam int CW = $clog2((HOLD_CYC > GAP_CYC ? HOLD_CYC : GAP_CYC) + 1);
   localparam logic [2:0] OP_INQ = 3'd1, OP_READ = 3'd2;
   state_t state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [2:0]  op_q, op_d;
   logic [15:0] words_q, words_d, stat_cnt_q, stat_cnt_d;
   logic [31:0] word_q, word_d, select_q, select_d, resp_data_q, resp_data_d;
   logic        resp_valid_q, resp_valid_d, resp_last_q, resp_last_d, full_q, full_d;
   always_comb begin
      state_d = state_q;
      cnt_d = cnt_q;
      op_d = op_q;
      words_d = words_q;
      word_d = word_q;
      select_d = select_q;
      resp_valid_d = 1'b0;
      resp_data_d = resp_data_q;
      resp_last_d = resp_last_q;
      full_d = full_q;
      stat_cnt_d = stat_cnt_q;
      if (state_q == IDLE) begin
         if (CMD_valid_in) begin
            op_d = CMD_op_in;
            word_d = {2'b00, CMD_op_in[2] ? CMD_arg_in[13:0] : 14'd0, 16'd1 << CMD_op_in};
            words_d = (CMD_op_in == OP_READ) ? CMD_arg_in : 16'd1;
            if (!(CMD_op_in == OP_READ && CMD_arg_in == 16'd0)) begin
               state_d = ASSERT;
               cnt_d = '0;
               select_d = word_d;
            end
         end
      end else if (state_q == ASSERT) begin
         cnt_d = cnt_q + 1'b1;
         if (cnt_q == CW'(SETTLE_CYC) && (op_q == OP_INQ || op_q == OP_READ)) begin
            resp_valid_d = 1'b1;
            resp_data_d = GPIO_in;
            resp_last_d = (op_q == OP_INQ) || (words_q == 16'd1);
            full_d = (op_q == OP_INQ) ? GPIO_in[16] : full_q;
            stat_cnt_d = (op_q == OP_INQ) ? GPIO_in[15:0] : stat_cnt_q;
            words_d = (op_q == OP_READ) ? words_q - 16'd1 : words_q;
         end
         if (cnt_q == CW'(HOLD_CYC - 1)) begin
            select_d = '0;
            state_d = GAP;
            cnt_d = '0;
         end
      end else begin
         cnt_d = cnt_q + 1'b1;
         if (cnt_q == CW'(GAP_CYC - 1)) begin
            cnt_d = '0;
            state_d = (op_q == OP_READ && words_q != 16'd0) ? ASSERT : IDLE;
            select_d = (op_q == OP_READ && words_q != 16'd0) ? word_q : '0;
         end
      end
   end
   always_ff @(posedge sys_clk or negedge _RESET_in) begin
      if (!_RESET_in) begin
         state_q <= IDLE;
         cnt_q <= '0;
         op_q <= '0;
         words_q <= '0;
         word_q <= '0;
         select_q <= '0;
         resp_valid_q <= 1'b0;
         resp_data_q <= '0;
         resp_last_q <= 1'b0;
         full_q <= 1'b0;
         stat_cnt_q <= '0;
      end else begin
         state_q <= state_d;
         cnt_q <= cnt_d;
         op_q <= op_d;
         words_q <= words_d;
         word_q <= word_d;
         select_q <= select_d;
         resp_valid_q <= resp_valid_d;
         resp_data_q <= resp_data_d;
         resp_last_q <= resp_last_d;
         full_q <= full_d;
         stat_cnt_q <= stat_cnt_d;
      end
   end
   assign CMD_ready_out = (state_q == IDLE);
   assign BUSY_out = (state_q != IDLE);
   assign SELECT_out = select_q;
   assign RESP_valid_out = resp_valid_q;
   assign RESP_data_out = resp_data_q;
   assign RESP_last_out = resp_last_q;
   assign STATUS_full_out = full_q;
   assign STATUS_cnt_out = stat_cnt_q;
endmodule
